// File: rtl/i2c_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_mon_pkg
// Description : Shared types, constants and helpers for the passive I2C bus
//               monitor (FSM states, byte record, 10-bit address prefix).
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_mon_pkg;

  // Bus-phase FSM: waiting for START, collecting data bits, waiting for ACK
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    ACK  = 2'd2
  } mon_state_t;

  localparam logic [4:0] TEN_BIT_PREFIX = 5'b11110;
  localparam int         I2C_BYTE_BITS  = 8;

  // The record index is wide enough for any practical IDX_W; the top clamps
  // it onto its own port width.
  localparam int IDX_REC_W = 16;

  typedef struct packed {
    logic [I2C_BYTE_BITS-1:0] data;
    logic                     ack;
    logic                     is_addr;
    logic [IDX_REC_W-1:0]     idx;
  } byte_rec_t;

  // First address byte of a 10-bit write: 11110xx0
  function automatic logic is_ten_bit_first(input logic [I2C_BYTE_BITS-1:0] b);
    return (b[7:3] == TEN_BIT_PREFIX) && !b[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : Synchroniser plus run-length deglitch for one open-drain line.
//               The filtered level flips only after FILTER_LEN consecutive
//               synchronised samples disagree with it.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       run_cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // Shift the raw line through the synchroniser chain (idle bus level is 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive disagreeing samples; adopt the new level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= 1'b1;
      run_cnt <= '0;
    end else if (synced == level) begin
      run_cnt <= '0;
    end else if (run_cnt == RUN_LAST) begin
      level   <= synced;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_monitor
// Description : Passive I2C bus monitor. Filters SCL/SDA, detects START,
//               repeated START and STOP, decodes bytes with ACK/NACK and
//               flags misplaced START/STOP and SCL-low timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TEN_BIT_EN  = 1,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic             enable,
  output logic             scl_f_o,
  output logic             sda_f_o,
  output logic             bus_busy_o,
  output logic             start_o,
  output logic             rstart_o,
  output logic             stop_o,
  output logic             byte_valid_o,
  output logic [7:0]       byte_data_o,
  output logic             byte_ack_o,
  output logic             byte_is_addr_o,
  output logic [IDX_W-1:0] byte_idx_o,
  output logic             err_misplaced_o,
  output logic             err_timeout_o
);

  localparam int              TO_W       = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_SAT     = TO_W'(TIMEOUT_CYC + 1);
  localparam logic [3:0]      LAST_BIT   = 4'(I2C_BYTE_BITS - 1);
  localparam logic            TEN_BIT_ON = (TEN_BIT_EN != 0);

  logic scl_f, sda_f, scl_prev, sda_prev;
  logic scl_rise, scl_fall, start_cond, stop_cond, timeout_hit, partial;
  logic go_start, go_rstart, go_stop, go_misplaced, go_shift, go_byte, go_timeout;

  mon_state_t              state, state_n;
  logic [3:0]              bitcnt;
  logic                    high_counted;
  logic [I2C_BYTE_BITS-1:0] shreg;
  logic [IDX_W-1:0]        idx;
  logic                    cur_addr;
  logic [TO_W-1:0]         tcnt;
  byte_rec_t               rec;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (scl_i),
    .level(scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sda_i),
    .level(sda_f)
  );

  assign scl_f_o    = scl_f;
  assign sda_f_o    = sda_f;
  assign scl_rise   = scl_f & ~scl_prev;
  assign scl_fall   = ~scl_f & scl_prev;
  // SDA edge with SCL steady high; a simultaneous SCL change is data-phase.
  assign start_cond = scl_prev & scl_f & sda_prev & ~sda_f;
  assign stop_cond  = scl_prev & scl_f & ~sda_prev & sda_f;
  assign timeout_hit = bus_busy_o & ~scl_f & (tcnt == TO_LIMIT);
  // A START/STOP happens inside the high phase of a clock the master just
  // raised; that rise is not a data bit, so discount it when judging placement.
  assign partial    = (bitcnt != {3'b000, high_counted});

  assign byte_data_o    = rec.data;
  assign byte_ack_o     = rec.ack;
  assign byte_is_addr_o = rec.is_addr;
  // Clamp the wide record index onto the port width.
  assign byte_idx_o     = (|(rec.idx >> IDX_W)) ? '1 : rec.idx[IDX_W-1:0];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and event decode; disable forces IDLE and silences all events.
  always_comb begin
    state_n      = state;
    go_start     = 1'b0;
    go_rstart    = 1'b0;
    go_stop      = 1'b0;
    go_misplaced = 1'b0;
    go_shift     = 1'b0;
    go_byte      = 1'b0;
    go_timeout   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_cond) begin
            go_start = 1'b1;
            state_n  = BITS;
          end else if (stop_cond) begin
            go_stop = 1'b1;
          end
        end
        BITS, ACK: begin
          if (timeout_hit) begin
            go_timeout = 1'b1;
            state_n    = IDLE;
          end else if (start_cond) begin
            go_rstart    = 1'b1;
            go_misplaced = partial;
            state_n      = BITS;
          end else if (stop_cond) begin
            go_stop      = 1'b1;
            go_misplaced = partial;
            state_n      = IDLE;
          end else if (scl_rise) begin
            if (state == BITS) begin
              go_shift = 1'b1;
              if (bitcnt == LAST_BIT) state_n = ACK;
            end else begin
              go_byte = 1'b1;
              state_n = BITS;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Edge history, event pulses, timeout counter and byte assembly datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev        <= 1'b1;
      sda_prev        <= 1'b1;
      bus_busy_o      <= 1'b0;
      start_o         <= 1'b0;
      rstart_o        <= 1'b0;
      stop_o          <= 1'b0;
      byte_valid_o    <= 1'b0;
      err_misplaced_o <= 1'b0;
      err_timeout_o   <= 1'b0;
      tcnt            <= '0;
      bitcnt          <= '0;
      high_counted    <= 1'b0;
      shreg           <= '0;
      idx             <= '0;
      cur_addr        <= 1'b0;
      rec             <= '0;
    end else begin
      scl_prev        <= scl_f;
      sda_prev        <= sda_f;
      bus_busy_o      <= (state_n != IDLE);
      start_o         <= go_start;
      rstart_o        <= go_rstart;
      stop_o          <= go_stop;
      byte_valid_o    <= go_byte;
      err_misplaced_o <= go_misplaced;
      err_timeout_o   <= go_timeout;

      if (!bus_busy_o || scl_f) begin
        tcnt <= '0;
      end else if (tcnt != TO_SAT) begin
        tcnt <= tcnt + TO_W'(1);
      end

      if (go_start || go_rstart) begin
        bitcnt       <= '0;
        high_counted <= 1'b0;
        idx          <= '0;
        cur_addr     <= 1'b1;
      end else if (state_n == IDLE) begin
        bitcnt       <= '0;
        high_counted <= 1'b0;
      end else if (go_shift) begin
        shreg        <= {shreg[I2C_BYTE_BITS-2:0], sda_f};
        bitcnt       <= bitcnt + 4'd1;
        high_counted <= 1'b1;
      end else if (go_byte) begin
        rec.data    <= shreg;
        rec.ack     <= ~sda_f;
        rec.is_addr <= cur_addr;
        rec.idx     <= IDX_REC_W'(idx);
        if (idx != '1) idx <= idx + IDX_W'(1);
        // Only the first byte of a 10-bit write promotes its successor.
        cur_addr     <= TEN_BIT_ON && (idx == '0) && is_ten_bit_first(shreg);
        bitcnt       <= '0;
        high_counted <= 1'b0;
      end else if (scl_fall) begin
        high_counted <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Synthesizable passive I2C bus monitor. Samples raw SCL/SDA asynchronously to clk, then synchronises and deglitches them.
- Detects START, repeated START and STOP, and decodes address/data bytes with their ACK/NACK.
- Flags protocol errors: misplaced START/STOP and SCL-low timeout.
- Sits beside the triand I2C bus in DUT-side logic and in bench harnesses; it is the RTL successor to the assertion-only bus checks.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per line (>=2).
- FILTER_LEN, 3, consecutive equal samples required before a filtered level changes (>=1).
- TIMEOUT_CYC, 4096, max clk cycles SCL may stay low while bus busy.
- TEN_BIT_EN, 1, when 1 a first byte matching 11110xx0 makes the next byte an address byte too.
- IDX_W, 8, width of the byte index counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scl_i  in  1  raw SCL level, asynchronous
- sda_i  in  1  raw SDA level, asynchronous
- enable  in  1  monitor enable; 0 holds FSM in IDLE and suppresses all pulses
- scl_f_o  out  1  filtered SCL
- sda_f_o  out  1  filtered SDA
- bus_busy_o  out  1  high from START to STOP/timeout
- start_o  out  1  1-cycle pulse, START from idle
- rstart_o  out  1  1-cycle pulse, START while busy
- stop_o  out  1  1-cycle pulse, STOP
- byte_valid_o  out  1  1-cycle pulse, byte+ACK complete
- byte_data_o  out  8  byte, MSB first on wire; held until next byte_valid
- byte_ack_o  out  1  1 = ACK (SDA low on 9th clock)
- byte_is_addr_o  out  1  byte is an address byte
- byte_idx_o  out  IDX_W  index since last (r)START, 0 = first; saturates at all-ones
- err_misplaced_o  out  1  pulse: START or STOP with bit count not 0
- err_timeout_o  out  1  pulse: SCL low > TIMEOUT_CYC while busy

Behaviour:
- Reset: sync flops, filter state and scl_f/sda_f = 1. All other outputs 0. FSM = IDLE.
- Filter: each filtered line toggles only after FILTER_LEN consecutive synchronised samples differ from the current level.
- Edge detection compares filtered levels with their previous-cycle values.
- Latency from raw input change to event pulse is SYNC_STAGES+FILTER_LEN+1 cycles (6 at defaults).
- START: SDA falls while SCL high in the previous and current cycle. STOP: SDA rises under the same condition.
- SCL and SDA changing in the same cycle is not START/STOP and is treated as a data-phase change.
- FSM states: IDLE, BITS, ACK.
  - IDLE: START -> start_o, BITS; bitcnt=0; idx=0; first byte is an address byte.
  - BITS: each SCL rise shifts sda_f into shreg, bitcnt++. On the 8th rise -> ACK.
  - ACK: the 9th SCL rise samples ack = ~sda_f. byte_valid_o pulses the next cycle with data/ack/is_addr/idx; then idx++ (saturating), bitcnt=0, -> BITS.
  - BITS/ACK, START: rstart_o pulses; idx=0; next byte is an address byte. err_misplaced_o if bitcnt != 0 (the partial byte is discarded) -> BITS.
  - BITS/ACK, STOP: stop_o -> IDLE. err_misplaced_o if bitcnt != 0; the partial byte is discarded.
- 10-bit mode: with TEN_BIT_EN=1, if the first address byte[7:3]=11110 and byte[0]=0, the byte at idx 1 also reports byte_is_addr_o=1. A repeated START followed by 11110xx1 is a single address byte.
- STOP in IDLE: stop_o pulses, no error.
- Timeout: counter runs while bus_busy_o && !scl_f and clears on scl_f high. It saturates at TIMEOUT_CYC+1. On reaching TIMEOUT_CYC+1: err_timeout_o pulses once, FSM -> IDLE, bus_busy_o=0.
- enable falling mid-transfer: FSM -> IDLE next cycle, busy cleared, no pulses. Filters keep running. Re-enable waits for the next START.
- bus_busy_o is registered: it rises in the same cycle as start_o and falls in the same cycle as stop_o/err_timeout_o.
- Asynchronous reset at any point returns everything to reset values within the reset assertion.

Decomposition:
- Shared package i2c_mon_pkg holds:
  - state enum (IDLE, BITS, ACK);
  - constants TEN_BIT_PREFIX=5'b11110, I2C_BYTE_BITS=8;
  - byte record struct (data, ack, is_addr, idx).
- One sub-module i2c_line_filter (synchroniser + FILTER_LEN deglitch, single line), instantiated for SCL and SDA.

Test Plan:
- Write 0x50 (addr byte 0xA0, ACK) then data 0x3C ACK, STOP -> start_o; byte_valid with 0xA0/ack=1/is_addr=1/idx=0; then 0x3C/ack=1/is_addr=0/idx=1; stop_o; busy low after stop.
- 2-cycle SDA glitch while SCL high, FILTER_LEN=3 -> no start_o/stop_o; sda_f_o unchanged.
- Addr 0xA0 ACK, repeated START, addr 0xA1 NACK, STOP -> rstart_o once; second byte idx=0/is_addr=1/ack=0; no errors.
- 10-bit: 0xF2 ACK, 0x55 ACK, 0x11 ACK -> is_addr=1,1,0 at idx 0,1,2.
- STOP after 4 data bits -> err_misplaced_o pulse, no byte_valid, FSM IDLE.
- TIMEOUT_CYC=16, hold SCL low 40 cycles after START -> single err_timeout_o about 17 cycles after filtered SCL falls; busy 0; subsequent STOP gives stop_o only.
